// File: rtl/frame_window_writer.sv
// rtl/frame_window_writer.sv - crops, packs and places a pixel stream into a framebuffer write port
//
// Ports:
//   clk10MHz, rstMain       pixel clock, asynchronous active-low reset
//   sof                     start-of-frame strobe (one cycle)
//   pix_valid, pix_data     incoming pixel {R,G,B}, IN_BITS per channel
//   bypass                  1 = raw stream, 0 = filtered stream (border cropped)
//   wr_en, wr_addr, wr_data registered RAM write port
//   frame_done              pulse with the last pixel's write slot
//   overrun                 pulse when sof arrives mid-frame
//   x_o, y_o                current column / line counters
module frame_window_writer #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int FB_W     = 640,
    parameter int FB_H     = 480,
    parameter int OFF_X    = 160,
    parameter int OFF_Y    = 120,
    parameter int KERNEL   = 3,
    parameter int ADDR_W   = 19
) (
    input  logic                         clk10MHz,
    input  logic                         rstMain,
    input  logic                         sof,
    input  logic                         pix_valid,
    input  logic [3*IN_BITS-1:0]         pix_data,
    input  logic                         bypass,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [3*OUT_BITS-1:0]        wr_data,
    output logic                         frame_done,
    output logic                         overrun,
    output logic [$clog2(IMG_W):0]       x_o,
    output logic [$clog2(IMG_H):0]       y_o
);

    localparam int XW   = $clog2(IMG_W) + 1;
    localparam int YW   = $clog2(IMG_H) + 1;
    localparam int CROP = KERNEL - 1;

    // Address = row_base + constant + x. The filter constant folds in the
    // -CROP line and -CROP column shift; it may be "negative" and relies on
    // modulo-2^ADDR_W wrap, which the placement check below keeps in range.
    localparam int BASE_BYP_I = OFF_Y * FB_W + OFF_X;
    localparam int BASE_FLT_I = BASE_BYP_I - CROP * FB_W - CROP;

    localparam logic [ADDR_W-1:0] BASE_BYP = ADDR_W'(BASE_BYP_I);
    localparam logic [ADDR_W-1:0] BASE_FLT = ADDR_W'(BASE_FLT_I);
    localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(FB_W);
    localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
    localparam logic [XW-1:0]     X_CROP   = XW'(CROP);
    localparam logic [YW-1:0]     Y_CROP   = YW'(CROP);

    if ((OFF_X + IMG_W > FB_W) || (OFF_Y + IMG_H > FB_H) ||
        (FB_W * FB_H - 1 >= 2 ** ADDR_W) || (KERNEL < 1) ||
        (OUT_BITS > IN_BITS) || (CROP >= IMG_W) || (CROP >= IMG_H)) begin : g_bad_params
        $error("frame_window_writer: image placement does not fit the framebuffer");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d, cx;
    logic [YW-1:0]       y_q, y_d, cy;
    logic [ADDR_W-1:0]   row_q, row_d, crow;
    logic                mode_q, mode_d, cmode;
    logic                take, qual, last_col, last_px;
    logic                wr_en_d, frame_done_d, overrun_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [3*OUT_BITS-1:0] wr_data_d;

    // Only the channel MSBs reach the RAM.
    wire unused_pix_bits = &{1'b0, pix_data};

    always_ff @(posedge clk10MHz or negedge rstMain) begin
        if (!rstMain) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            row_q      <= '0;
            mode_q     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        row_d        = row_q;
        mode_d       = mode_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        cx           = x_q;
        cy           = y_q;
        crow         = row_q;
        cmode        = mode_q;

        // sof restarts from any state; a pixel in the same cycle is (0,0)
        // of the new frame, so the "current" coordinates are forced to zero.
        if (sof) begin
            overrun_d = (state_q == ACTIVE);
            state_d   = ACTIVE;
            cx        = '0;
            cy        = '0;
            crow      = '0;
            cmode     = bypass;
            x_d       = '0;
            y_d       = '0;
            row_d     = '0;
            mode_d    = bypass;
        end

        take     = pix_valid && (sof || (state_q == ACTIVE));
        last_col = (cx == X_LAST);
        last_px  = last_col && (cy == Y_LAST);
        qual     = cmode || ((cx >= X_CROP) && (cy >= Y_CROP));

        if (take) begin
            if (qual) begin
                wr_en_d   = 1'b1;
                wr_addr_d = crow + (cmode ? BASE_BYP : BASE_FLT) + ADDR_W'(cx);
                wr_data_d = {pix_data[3*IN_BITS-1 -: OUT_BITS],
                             pix_data[2*IN_BITS-1 -: OUT_BITS],
                             pix_data[IN_BITS-1   -: OUT_BITS]};
            end
            if (last_px) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
                x_d          = '0;
                y_d          = '0;
                row_d        = '0;
            end else if (last_col) begin
                x_d   = '0;
                y_d   = cy + YW'(1);
                row_d = crow + PITCH;
            end else begin
                x_d = cx + XW'(1);
            end
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: tb/tb_frame_window_writer.sv
// tb/tb_frame_window_writer.sv - randomized self-checking bench for frame_window_writer
module tb_frame_window_writer;

    localparam int IMG_W = 4, IMG_H = 3, FB_W = 8, FB_H = 6;
    localparam int OFF_X = 2, OFF_Y = 1, KERNEL = 3, CROP = KERNEL - 1;
    localparam int ADDR_W = 6;

    logic        clk10MHz = 1'b0;
    logic        rstMain = 1'b0;
    logic        sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        bypass = 1'b0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_done;
    logic        overrun;
    logic [2:0]  x_o;
    logic [2:0]  y_o;

    frame_window_writer #(
        .IN_BITS(8), .OUT_BITS(4), .IMG_W(IMG_W), .IMG_H(IMG_H), .FB_W(FB_W),
        .FB_H(FB_H), .OFF_X(OFF_X), .OFF_Y(OFF_Y), .KERNEL(KERNEL), .ADDR_W(ADDR_W)
    ) dut (
        .clk10MHz(clk10MHz), .rstMain(rstMain), .sof(sof), .pix_valid(pix_valid),
        .pix_data(pix_data), .bypass(bypass), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .overrun(overrun),
        .x_o(x_o), .y_o(y_o)
    );

    always #50 clk10MHz = ~clk10MHz;

    int checks = 0;
    int failures = 0;

    // Reference model: a frame is just a pixel index 0..IMG_W*IMG_H-1.
    bit       m_active;
    bit       m_mode;
    int       m_idx;
    logic     e_en, e_done, e_ovr;
    int       e_addr;
    logic [11:0] e_data;

    logic [26:0] obs, expv;
    int wr_log[$];
    int done_log[$];

    task automatic model_reset();
        m_active = 0; m_mode = 0; m_idx = 0;
        e_en = 0; e_done = 0; e_ovr = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [23:0] d, input logic b);
        int px, py;
        e_ovr  = s && m_active;
        e_en   = 0;
        e_done = 0;
        if (s) begin
            m_active = 1; m_mode = b; m_idx = 0;
        end
        if (v && m_active) begin
            px = m_idx % IMG_W;
            py = m_idx / IMG_W;
            if (m_mode || (px >= CROP && py >= CROP)) begin
                e_en   = 1;
                e_addr = m_mode ? (py + OFF_Y) * FB_W + px + OFF_X
                                : (py - CROP + OFF_Y) * FB_W + (px - CROP) + OFF_X;
                e_data = {d[23:20], d[15:12], d[7:4]};
            end
            if (m_idx == IMG_W * IMG_H - 1) begin
                e_done = 1; m_active = 0; m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [23:0] d, input logic b);
        sof = s; pix_valid = v; pix_data = d; bypass = b;
        @(posedge clk10MHz);
        model_step(s, v, d, b);
        #1;
        obs  = {wr_en, wr_addr, wr_data, frame_done, overrun, x_o, y_o};
        expv = {e_en, 6'(e_addr), e_data, e_done, e_ovr,
                3'(m_idx % IMG_W), 3'(m_idx / IMG_W)};
        if (wr_en) wr_log.push_back(int'(wr_addr));
        if (frame_done) done_log.push_back(int'(wr_addr));
        sof = 1'b0; pix_valid = 1'b0;
    endtask

    function automatic logic [23:0] rnd_pix();
        return 24'($urandom());
    endfunction

    task automatic test_reset();
        rstMain = 1'b0;
        model_reset();
        repeat (3) @(posedge clk10MHz);
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, overrun, x_o, y_o} !== 27'd0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", {wr_en, wr_addr, wr_data, frame_done, overrun, x_o, y_o});
        end
        rstMain = 1'b1;
    endtask

    task automatic test_bypass_frame();
        int exp_a[12] = '{10, 11, 12, 13, 18, 19, 20, 21, 26, 27, 28, 29};
        wr_log.delete(); done_log.delete();
        for (int i = 0; i < 14; i++) begin
            step(i == 0, 1'b1, rnd_pix(), 1'b1);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL bypass_frame cyc=%0d got=%h want=%h", i, obs, expv);
            end
        end
        checks++;
        if (wr_log.size() != 12) begin
            failures++;
            $display("FAIL bypass_count got=%0d want=12", wr_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (wr_log[i] != exp_a[i]) begin
                    failures++;
                    $display("FAIL bypass_addr idx=%0d got=%0d want=%0d", i, wr_log[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 29) begin
            failures++;
            $display("FAIL bypass_done got_count=%0d want one pulse at addr 29", done_log.size());
        end
    endtask

    task automatic test_filter_frame();
        wr_log.delete(); done_log.delete();
        for (int i = 0; i < 13; i++) begin
            step(i == 0, 1'b1, rnd_pix(), 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL filter_frame cyc=%0d got=%h want=%h", i, obs, expv);
            end
        end
        checks++;
        if (wr_log.size() != 2 || wr_log[0] != 10 || wr_log[1] != 11) begin
            failures++;
            $display("FAIL filter_addrs got_count=%0d want 2 writes at 10,11", wr_log.size());
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 11) begin
            failures++;
            $display("FAIL filter_done got_count=%0d want one pulse at addr 11", done_log.size());
        end
    endtask

    task automatic test_pack();
        step(1'b1, 1'b1, 24'hA53CF0, 1'b1);
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 12'hA3F || wr_addr !== 6'd10) begin
            failures++;
            $display("FAIL pack got en=%b data=%h addr=%0d want en=1 data=a3f addr=10", wr_en, wr_data, wr_addr);
        end
        for (int i = 1; i < 12; i++) step(1'b0, 1'b1, rnd_pix(), 1'b1);
    endtask

    task automatic test_overrun();
        wr_log.delete(); done_log.delete();
        for (int i = 0; i < 5; i++) step(i == 0, 1'b1, rnd_pix(), 1'b1);
        step(1'b1, 1'b0, rnd_pix(), 1'b1);
        checks++;
        if (overrun !== 1'b1 || obs !== expv) begin
            failures++;
            $display("FAIL overrun_pulse got=%h want=%h", obs, expv);
        end
        wr_log.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, rnd_pix(), 1'b1);
            checks++;
            if (obs !== expv || (i == 0 && overrun !== 1'b0)) begin
                failures++;
                $display("FAIL overrun_frame cyc=%0d got=%h want=%h", i, obs, expv);
            end
        end
        checks++;
        if (wr_log.size() != 12 || wr_log[0] != 10 || done_log.size() != 1) begin
            failures++;
            $display("FAIL overrun_restart writes=%0d dones=%0d want 12 writes from 10 and 1 done", wr_log.size(), done_log.size());
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 6; i++) step(i == 0, 1'b1, rnd_pix(), 1'b1);
        #20;
        rstMain = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, overrun, x_o, y_o} !== 27'd0) begin
            failures++;
            $display("FAIL midframe_reset got=%h want=0", {wr_en, wr_addr, wr_data, frame_done, overrun, x_o, y_o});
        end
        @(posedge clk10MHz);
        #10;
        rstMain = 1'b1;
        wr_log.delete(); done_log.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, rnd_pix(), 1'b1);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL no_sof_pixels cyc=%0d got=%h want=%h", i, obs, expv);
            end
        end
        checks++;
        if (wr_log.size() != 0 || done_log.size() != 0) begin
            failures++;
            $display("FAIL no_sof_writes got=%0d want=0", wr_log.size());
        end
        step(1'b1, 1'b1, rnd_pix(), 1'b1);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd10) begin
            failures++;
            $display("FAIL resume_after_reset got en=%b addr=%0d want en=1 addr=10", wr_en, wr_addr);
        end
        for (int i = 1; i < 12; i++) step(1'b0, 1'b1, rnd_pix(), 1'b1);
    endtask

    task automatic test_mode_latch_gaps();
        wr_log.delete(); done_log.delete();
        step(1'b1, 1'b1, rnd_pix(), 1'b0);
        for (int p = 1; p < 12; p++) begin
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0, rnd_pix(), p > 5);
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL gap_cycle px=%0d got=%h want=%h", p, obs, expv);
                end
            end
            step(1'b0, 1'b1, rnd_pix(), p > 5);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL gap_pixel px=%0d got=%h want=%h", p, obs, expv);
            end
        end
        checks++;
        if (wr_log.size() != 2 || wr_log[0] != 10 || wr_log[1] != 11 ||
            done_log.size() != 1 || done_log[0] != 11) begin
            failures++;
            $display("FAIL mode_latch writes=%0d dones=%0d want writes 10,11 and done at 11", wr_log.size(), done_log.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, rnd_pix(), 1'($urandom()));
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass_frame();
        test_filter_frame();
        test_pack();
        test_overrun();
        test_reset_midframe();
        test_mode_latch_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
